// File: rtl/gshare_predictor.sv
// gshare global branch predictor.
// The speculative global history is XORed with PC bits to index a table of
// saturating counters. The prediction is returned combinationally, and the
// index plus a history snapshot travel down the pipeline with the branch.
// When the branch resolves, its counter is trained; on a mispredict the
// history is rebuilt from the snapshot.
// After reset, the table is swept to weakly-not-taken before predictions
// are reported as valid.
module gshare_predictor #(
    parameter int HIST_W = 8,
    parameter int CTR_W  = 2,
    parameter int PC_LSB = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pc_in,
    input  logic              predict_valid,
    input  logic              stall,
    output logic              predict_taken,
    output logic [HIST_W-1:0] predict_index,
    output logic [HIST_W-1:0] predict_bhr,
    input  logic              resolve_valid,
    input  logic [HIST_W-1:0] resolve_index,
    input  logic [HIST_W-1:0] resolve_bhr,
    input  logic              resolve_taken,
    input  logic              resolve_mispredict,
    output logic [HIST_W-1:0] bhr_out,
    output logic              ready
);

    localparam int DEPTH = 1 << HIST_W;
    localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN = {CTR_W{1'b0}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [HIST_W-1:0]  init_ptr_r;
    logic [HIST_W-1:0]  init_ptr_s;
    logic [HIST_W-1:0]  spec_bhr_r;
    logic [HIST_W-1:0]  bhr_next_s;
    logic [CTR_W-1:0]   pht_r [DEPTH];

    logic               ready_s;
    logic [HIST_W-1:0]  idx_s;
    logic               taken_s;
    logic               accept_s;
    logic               repair_s;
    logic               train_s;
    logic               unused_s;

    // Saturating step of one counter: up on taken, down on not-taken, never wraps.
    function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] ctr,
                                                  input logic             up);
        logic [CTR_W-1:0] res;
        res = ctr;
        if (up) begin
            if (ctr != CTR_MAX) begin
                res = ctr + {{(CTR_W-1){1'b0}}, 1'b1};
            end else begin
                res = ctr;
            end
        end else begin
            if (ctr != CTR_MIN) begin
                res = ctr - {{(CTR_W-1){1'b0}}, 1'b1};
            end else begin
                res = ctr;
            end
        end
        return res;
    endfunction

    // PC bits outside the index window and the snapshot MSB carry no information here.
    assign unused_s = ^{pc_in[31:PC_LSB+HIST_W], pc_in[PC_LSB-1:0], resolve_bhr[HIST_W-1]};

    // Init sweep sequencing: walk every entry once, then enter RUN.
    always_comb begin
        state_s    = state_r;
        init_ptr_s = init_ptr_r;
        case (state_r)
            ST_INIT: begin
                init_ptr_s = init_ptr_r + {{(HIST_W-1){1'b0}}, 1'b1};
                if (init_ptr_r == {HIST_W{1'b1}}) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_RUN: begin
                state_s    = ST_RUN;
                init_ptr_s = init_ptr_r;
            end
            default: begin
                state_s    = ST_INIT;
                init_ptr_s = {HIST_W{1'b0}};
            end
        endcase
    end

    // Prediction lookup and control qualifiers; table reads see pre-update contents.
    always_comb begin
        ready_s  = (state_r == ST_RUN);
        idx_s    = spec_bhr_r ^ pc_in[PC_LSB+HIST_W-1:PC_LSB];
        if (ready_s) begin
            taken_s = pht_r[idx_s][CTR_W-1];
        end else begin
            taken_s = 1'b0;
        end
        accept_s = ready_s & predict_valid & ~stall;
        train_s  = ready_s & resolve_valid;
        repair_s = train_s & resolve_mispredict;
    end

    // Next speculative history: a repair from the older branch overrides a younger shift.
    always_comb begin
        bhr_next_s = spec_bhr_r;
        if (repair_s) begin
            bhr_next_s = {resolve_bhr[HIST_W-2:0], resolve_taken};
        end else if (accept_s) begin
            bhr_next_s = {spec_bhr_r[HIST_W-2:0], taken_s};
        end else begin
            bhr_next_s = spec_bhr_r;
        end
    end

    // Control state, sweep pointer and speculative history registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_INIT;
            init_ptr_r <= {HIST_W{1'b0}};
            spec_bhr_r <= {HIST_W{1'b0}};
        end else begin
            state_r    <= state_s;
            init_ptr_r <= init_ptr_s;
            spec_bhr_r <= bhr_next_s;
        end
    end

    // Pattern table: init sweep writes weakly-not-taken, afterwards one training write per cycle.
    always_ff @(posedge clk) begin
        if (rst_n && (state_r == ST_INIT)) begin
            pht_r[init_ptr_r] <= CTR_WNT;
        end else if (rst_n && train_s) begin
            pht_r[resolve_index] <= sat_step(pht_r[resolve_index], resolve_taken);
        end
    end

    // Output drive; history is held at zero throughout the sweep.
    always_comb begin
        ready         = ready_s;
        predict_taken = taken_s;
        predict_index = idx_s;
        predict_bhr   = spec_bhr_r;
        bhr_out       = spec_bhr_r;
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor at HIST_W=4: stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_gshare_predictor;

    localparam int HW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   pc_in;
    logic          predict_valid;
    logic          stall;
    logic          predict_taken;
    logic [HW-1:0] predict_index;
    logic [HW-1:0] predict_bhr;
    logic          resolve_valid;
    logic [HW-1:0] resolve_index;
    logic [HW-1:0] resolve_bhr;
    logic          resolve_taken;
    logic          resolve_mispredict;
    logic [HW-1:0] bhr_out;
    logic          ready;

    typedef struct {
        string    name;
        int       kind;   // 0 ready, 1 predict_taken, 2 predict_index, 3 bhr_out, 4 predict_bhr
        logic [3:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    gshare_predictor #(.HIST_W(HW), .CTR_W(2), .PC_LSB(2)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in),
        .predict_valid(predict_valid), .stall(stall),
        .predict_taken(predict_taken), .predict_index(predict_index),
        .predict_bhr(predict_bhr), .resolve_valid(resolve_valid),
        .resolve_index(resolve_index), .resolve_bhr(resolve_bhr),
        .resolve_taken(resolve_taken), .resolve_mispredict(resolve_mispredict),
        .bhr_out(bhr_out), .ready(ready)
    );

    // Monitor: compare every expectation queued for this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [3:0] act;
            e = exp_q.pop_front();
            case (e.kind)
                0: act = {3'b000, ready};
                1: act = {3'b000, predict_taken};
                2: act = predict_index;
                3: act = bhr_out;
                4: act = predict_bhr;
                default: act = 4'hx;
            endcase
            n_vec++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic chk(input string name, input int kind, input logic [3:0] v);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        predict_valid      = 1'b0;
        stall              = 1'b0;
        resolve_valid      = 1'b0;
        resolve_index      = 4'd0;
        resolve_bhr        = 4'd0;
        resolve_taken      = 1'b0;
        resolve_mispredict = 1'b0;
    endtask

    // Choose pc_in so that idx = bhr ^ pc[5:2] equals the wanted index.
    task automatic set_pc(input logic [3:0] idx, input logic [3:0] bhr);
        pc_in = {26'd0, idx ^ bhr, 2'b00};
    endtask

    task automatic train(input logic [3:0] idx, input logic t);
        resolve_valid      = 1'b1;
        resolve_index      = idx;
        resolve_taken      = t;
        resolve_mispredict = 1'b0;
        step();
        resolve_valid      = 1'b0;
    endtask

    task automatic look(input string name, input logic [3:0] idx, input logic [3:0] bhr,
                        input logic t);
        predict_valid = 1'b0;
        set_pc(idx, bhr);
        chk(name, 1, {3'b000, t});
        step();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        pc_in = 32'd0;
        idle();
        step();
        step();
        rst_n = 1'b1;

        // Init sweep: inputs must be ignored, ready low for 16 edges.
        for (int i = 0; i < 16; i++) begin
            predict_valid      = 1'b1;
            pc_in              = {26'd0, 4'(i), 2'b00};
            resolve_valid      = 1'b1;
            resolve_index      = 4'(15 - i);
            resolve_taken      = 1'b1;
            resolve_mispredict = 1'b1;
            resolve_bhr        = 4'hF;
            chk("init_ready", 0, 4'd0);
            chk("init_taken", 1, 4'd0);
            chk("init_bhr", 3, 4'd0);
            step();
        end
        idle();
        chk("ready_after_sweep", 0, 4'd1);
        chk("bhr_after_sweep", 3, 4'd0);
        step();
        for (int i = 0; i < 16; i++) begin
            set_pc(4'(i), 4'd0);
            chk("sweep_taken", 1, 4'd0);
            chk("sweep_index", 2, 4'(i));
            step();
        end

        // Saturation at index 5 (starts at 01).
        train(4'd5, 1'b1); look("sat_10", 4'd5, 4'd0, 1'b1);
        train(4'd5, 1'b1); look("sat_11", 4'd5, 4'd0, 1'b1);
        train(4'd5, 1'b1); look("sat_hold11", 4'd5, 4'd0, 1'b1);
        train(4'd5, 1'b0); look("sat_dn10", 4'd5, 4'd0, 1'b1);
        train(4'd5, 1'b0); look("sat_dn01", 4'd5, 4'd0, 1'b0);
        train(4'd5, 1'b0); look("sat_dn00", 4'd5, 4'd0, 1'b0);
        train(4'd5, 1'b0); look("sat_hold00", 4'd5, 4'd0, 1'b0);
        train(4'd5, 1'b1); look("sat_up01", 4'd5, 4'd0, 1'b0);

        // Speculative history: outcomes 1,0,1 with a stalled cycle in between.
        train(4'd3, 1'b1);
        predict_valid = 1'b1;
        set_pc(4'd3, 4'd0);
        chk("spec_a_taken", 1, 4'd1);
        chk("spec_a_index", 2, 4'd3);
        chk("spec_a_pbhr", 4, 4'd0);
        chk("spec_a_bhr", 3, 4'd0);
        step();
        stall = 1'b1;
        set_pc(4'd3, 4'd1);
        chk("spec_stall_bhr", 3, 4'd1);
        step();
        stall = 1'b0;
        set_pc(4'd0, 4'd1);
        chk("spec_c_bhr", 3, 4'd1);
        chk("spec_c_pbhr", 4, 4'd1);
        chk("spec_c_taken", 1, 4'd0);
        step();
        set_pc(4'd3, 4'd2);
        chk("spec_d_bhr", 3, 4'd2);
        chk("spec_d_taken", 1, 4'd1);
        step();
        predict_valid = 1'b0;
        chk("spec_final_bhr", 3, 4'd5);
        n_vec++;
        if (bhr_out !== 4'd5) begin
            n_bad++;
            $display("FAIL spec_final_bhr_direct: got %h expected %h", bhr_out, 4'd5);
        end

        // Repair priority over a same-cycle accept that would shift in a 1.
        predict_valid      = 1'b1;
        set_pc(4'd3, 4'd5);
        resolve_valid      = 1'b1;
        resolve_mispredict = 1'b1;
        resolve_bhr        = 4'b0011;
        resolve_taken      = 1'b0;
        resolve_index      = 4'd15;
        chk("repair_acc_taken", 1, 4'd1);
        step();
        idle();
        chk("repair_bhr", 3, 4'b0110);
        n_vec++;
        if (bhr_out !== 4'b0110) begin
            n_bad++;
            $display("FAIL repair_bhr_direct: got %h expected %h", bhr_out, 4'b0110);
        end

        // Collision at index 9: read-before-write.
        set_pc(4'd9, 4'd6);
        resolve_valid = 1'b1;
        resolve_index = 4'd9;
        resolve_taken = 1'b1;
        chk("coll_same_taken", 1, 4'd0);
        chk("coll_index", 2, 4'd9);
        step();
        idle();
        chk("coll_next_taken", 1, 4'd1);
        n_vec++;
        if (predict_taken !== 1'b1) begin
            n_bad++;
            $display("FAIL coll_next_taken_direct: got %h expected %h", predict_taken, 1'b1);
        end
        step();

        // Train several entries to 11, then reset mid-run.
        train(4'd9, 1'b1);
        train(4'd3, 1'b1);
        train(4'd5, 1'b1);
        train(4'd5, 1'b1);
        look("pre_rst_3", 4'd3, 4'd6, 1'b1);
        look("pre_rst_5", 4'd5, 4'd6, 1'b1);
        look("pre_rst_9", 4'd9, 4'd6, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_pc(4'd3, 4'd0);
            chk("rst2_ready", 0, 4'd0);
            chk("rst2_bhr", 3, 4'd0);
            chk("rst2_taken", 1, 4'd0);
            step();
        end
        chk("rst2_ready_up", 0, 4'd1);
        n_vec++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst2_ready_up_direct: got %h expected %h", ready, 1'b1);
        end
        step();
        for (int i = 0; i < 16; i++) begin
            set_pc(4'(i), 4'd0);
            chk("rst2_sweep_taken", 1, 4'd0);
            step();
        end

        idle();
        @(negedge clk);
        #1;
        if (n_bad != 0) begin
            $display("FAIL summary: got %0d miscompares expected 0", n_bad);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
